// File: rtl/dequant_load_ctrl.sv
// rtl/dequant_load_ctrl.sv - streams scale words into block-RAM scale storage (IDLE/LOAD/DONE).
// Optional stall timeout is enabled by defining DEQUANT_LOAD_TIMEOUT_EN.
module dequant_load_ctrl #(
  parameter int          pWEIGHT_DATA_WIDTH = 64,
  parameter logic [31:0] pWEIGHT_BASE_ADDR  = 32'h4000_0000,
  parameter int          pDEQUANT_SCALE_NUM = 32,
  parameter int          pBLOCK_RAM_NUM     = 32,
  parameter int          pTIMEOUT_CYCLES    = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [pWEIGHT_DATA_WIDTH-1:0] s_data,
  output logic                          wr_en,
  output logic [31:0]                   weight_addr,
  output logic [pWEIGHT_DATA_WIDTH-1:0] weight_data,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int BW = (pBLOCK_RAM_NUM > 1) ? $clog2(pBLOCK_RAM_NUM) : 1;
  localparam int EW = (pDEQUANT_SCALE_NUM > 1) ? $clog2(pDEQUANT_SCALE_NUM) : 1;
  localparam logic [BW-1:0] BLK_LAST = BW'(pBLOCK_RAM_NUM - 1);
  localparam logic [EW-1:0] ENT_LAST = EW'(pDEQUANT_SCALE_NUM - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e                        state_q, state_d;
  logic [BW-1:0]                 blk_q, blk_d;
  logic [EW-1:0]                 ent_q, ent_d;
  logic                          wr_en_q;
  logic [31:0]                   addr_q;
  logic [pWEIGHT_DATA_WIDTH-1:0] data_q;
  logic                          beat;
  logic                          last_beat;

`ifdef DEQUANT_LOAD_TIMEOUT_EN
  localparam int SW = (pTIMEOUT_CYCLES > 1) ? $clog2(pTIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0] STALL_LAST = SW'(pTIMEOUT_CYCLES - 1);
  logic [SW-1:0] stall_q, stall_d;
  logic          err_q, err_d;
`endif

  // rst gating keeps the handshake closed while reset is held.
  assign s_ready   = !rst && (state_q == LOAD) && !abort;
  assign beat      = s_valid && s_ready;
  assign last_beat = beat && (blk_q == BLK_LAST) && (ent_q == ENT_LAST);

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    ent_d   = ent_q;
`ifdef DEQUANT_LOAD_TIMEOUT_EN
    stall_d = stall_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          blk_d   = '0;
          ent_d   = '0;
`ifdef DEQUANT_LOAD_TIMEOUT_EN
          stall_d = '0;
          err_d   = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          blk_d   = '0;
          ent_d   = '0;
        end else if (beat) begin
`ifdef DEQUANT_LOAD_TIMEOUT_EN
          stall_d = '0;
`endif
          if (last_beat) begin
            state_d = DONE;
            blk_d   = '0;
            ent_d   = '0;
          end else if (blk_q == BLK_LAST) begin
            blk_d = '0;
            ent_d = ent_q + 1'b1;
          end else begin
            blk_d = blk_q + 1'b1;
          end
        end else begin
`ifdef DEQUANT_LOAD_TIMEOUT_EN
          if (stall_q == STALL_LAST) begin
            state_d = IDLE;
            err_d   = 1'b1;
            blk_d   = '0;
            ent_d   = '0;
            stall_d = '0;
          end else begin
            stall_d = stall_q + 1'b1;
          end
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      blk_q   <= '0;
      ent_q   <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef DEQUANT_LOAD_TIMEOUT_EN
      stall_q <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      ent_q   <= ent_d;
      wr_en_q <= beat;
      if (beat) begin
        addr_q <= pWEIGHT_BASE_ADDR + 32'(ent_q);
        data_q <= s_data;
      end
`ifdef DEQUANT_LOAD_TIMEOUT_EN
      stall_q <= stall_d;
      err_q   <= err_d;
`endif
    end
  end

  assign wr_en       = wr_en_q;
  assign weight_addr = addr_q;
  assign weight_data = data_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
`ifdef DEQUANT_LOAD_TIMEOUT_EN
  assign err         = err_q;
`else
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_dequant_load_ctrl.sv
// tb/tb_dequant_load_ctrl.sv - directed self-checking bench for dequant_load_ctrl.
// Small geometry: 2 block RAMs x 4 entries, timeout 8 cycles.
module tb_dequant_load_ctrl;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst, start, abort, s_valid;
  logic        s_ready, wr_en, busy, done, err;
  logic [63:0] s_data, weight_data;
  logic [31:0] weight_addr;

  int checks = 0;
  int errors = 0;

  dequant_load_ctrl #(
    .pWEIGHT_DATA_WIDTH(64),
    .pWEIGHT_BASE_ADDR (BASE),
    .pDEQUANT_SCALE_NUM(4),
    .pBLOCK_RAM_NUM    (2),
    .pTIMEOUT_CYCLES   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .wr_en      (wr_en),
    .weight_addr(weight_addr),
    .weight_data(weight_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic begin_load();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
  endtask

  // Eight back-to-back beats; addresses step every second beat.
  task automatic load8(input int d0, input logic hold_start);
    start   = hold_start;
    s_valid = 1'b1;
    s_data  = 64'(d0);
    #1;
    chk("s_ready_load", s_ready, 1'b1);
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("b2b_wr_en", wr_en, 1'b1);
      chk("b2b_addr", weight_addr, BASE + 32'(k / 2));
      chk("b2b_data", weight_data, 64'(d0 + k));
      chk("b2b_done", done, (k == 7));
      if (k < 7) s_data = 64'(d0 + k + 1);
      else s_valid = 1'b0;
    end
    cyc();
    start = 1'b0;
    chk("post_done_busy", busy, 1'b0);
    chk("post_done_wr_en", wr_en, 1'b0);
    chk("post_done_done", done, 1'b0);
  endtask

  initial begin
    int writes;
    int dones;
    rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    cyc();
    cyc();
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_addr", weight_addr, 32'h0);
    chk("rst_data", weight_data, 64'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_s_ready", s_ready, 1'b0);
    rst = 1'b0;
    cyc();
    chk("idle_s_ready", s_ready, 1'b0);

    // Back-to-back load of data 1..8
    begin_load();
    load8(1, 1'b0);

    // Alternating valid: exactly one write per accepted beat
    begin_load();
    writes = 0;
    dones  = 0;
    for (int i = 0; i < 16; i++) begin
      s_valid = (i % 2 == 0);
      s_data  = 64'(100 + i / 2);
      cyc();
      chk("tog_wr_en", wr_en, (i % 2 == 0));
      if (wr_en) begin
        writes++;
        chk("tog_addr", weight_addr, BASE + 32'(i / 4));
        chk("tog_data", weight_data, 64'(100 + i / 2));
      end
      if (done) dones++;
    end
    s_valid = 1'b0;
    chk("tog_writes", 32'(writes), 32'd8);
    chk("tog_dones", 32'(dones), 32'd1);
    chk("tog_idle", busy, 1'b0);

    // Abort after three beats, then a clean reload
    begin_load();
    s_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_data = 64'(50 + k);
      cyc();
      chk("ab_addr", weight_addr, BASE + 32'(k / 2));
    end
    abort = 1'b1;
    #1;
    chk("ab_s_ready", s_ready, 1'b0);
    cyc();
    abort = 1'b0;
    s_valid = 1'b0;
    chk("ab_wr_en", wr_en, 1'b0);
    chk("ab_busy", busy, 1'b0);
    chk("ab_done", done, 1'b0);
    cyc();
    chk("ab_done2", done, 1'b0);
    begin_load();
    load8(20, 1'b0);

    // start held high through LOAD and DONE has no effect
    begin_load();
    load8(30, 1'b1);
    cyc();
    chk("idle_stays", busy, 1'b0);

    // Reset after five beats discards the load
    begin_load();
    s_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      s_data = 64'(40 + k);
      cyc();
    end
    chk("pre_rst_addr", weight_addr, BASE + 32'd2);
    rst = 1'b1;
    #1;
    chk("rst_mid_s_ready", s_ready, 1'b0);
    cyc();
    chk("rst_mid_wr_en", wr_en, 1'b0);
    chk("rst_mid_addr", weight_addr, 32'h0);
    chk("rst_mid_data", weight_data, 64'h0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    rst = 1'b0;
    s_valid = 1'b0;
    cyc();
    chk("rst_mid_done2", done, 1'b0);
    chk("rst_mid_busy2", busy, 1'b0);

    // Stall with no beats
    begin_load();
    for (int c = 0; c < 7; c++) cyc();
    chk("stall7_busy", busy, 1'b1);
    chk("stall7_err", err, 1'b0);
    cyc();
    chk("stall_done", done, 1'b0);
`ifdef DEQUANT_LOAD_TIMEOUT_EN
    chk("to_err", err, 1'b1);
    chk("to_busy", busy, 1'b0);
    cyc();
    chk("to_err_sticky", err, 1'b1);
    begin_load();
    chk("to_err_cleared", err, 1'b0);
`else
    chk("noto_err", err, 1'b0);
    chk("noto_busy", busy, 1'b1);
    for (int c = 0; c < 8; c++) cyc();
    chk("noto_busy_long", busy, 1'b1);
`endif
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("final_idle", busy, 1'b0);
    chk("final_done", done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
